eth_tx_stream_arbiter: RTL and testbench
========================================

Name: eth_tx_stream_arbiter

Overview:
Packet-level arbiter sharing the single 64-bit AXI-Stream Ethernet TX datapath between two frame sources: source 0 (ACK/control frame generator) and source 1 (RDMA data frame encapsulator). A granted source keeps the path until its tlast handshake, so frames are never interleaved. Round-robin fairness by default. Per-source frame counters are exported for status/debug.

Parameters:
DATA_WIDTH, 64, AXI-Stream data width in bits; tkeep width is DATA_WIDTH/8
CNT_WIDTH, 32, width of each per-source forwarded-frame counter

Ports:
clk  in  1  single clock, all logic on rising edge
rstn  in  1  asynchronous active-low reset
s0_axis_tdata  in  DATA_WIDTH  source 0 data
s0_axis_tkeep  in  DATA_WIDTH/8  source 0 byte enables
s0_axis_tvalid  in  1  source 0 valid
s0_axis_tready  out  1  source 0 ready
s0_axis_tlast  in  1  source 0 end of frame
s1_axis_tdata  in  DATA_WIDTH  source 1 data
s1_axis_tkeep  in  DATA_WIDTH/8  source 1 byte enables
s1_axis_tvalid  in  1  source 1 valid
s1_axis_tready  out  1  source 1 ready
s1_axis_tlast  in  1  source 1 end of frame
m_axis_tdata  out  DATA_WIDTH  shared TX data
m_axis_tkeep  out  DATA_WIDTH/8  shared TX byte enables
m_axis_tvalid  out  1  shared TX valid
m_axis_tready  in  1  shared TX ready
m_axis_tlast  out  1  shared TX end of frame
busy  out  1  1 while a frame owns the path
grant_id  out  1  source currently (or last) granted
frame_cnt0  out  CNT_WIDTH  frames completed from source 0
frame_cnt1  out  CNT_WIDTH  frames completed from source 1

Behaviour:
- Reset (async, rstn=0): state=IDLE, busy=0, grant_id=0, last_grant=1, frame_cnt0/1=0. m_axis_tvalid=0, m_axis_tdata/tkeep/tlast=0, both s*_axis_tready=0.
- States: IDLE, BUSY.
- IDLE: m_axis_* driven 0, both s_tready=0. If any s*_tvalid=1, register grant and go BUSY next edge. Only one source valid: that source is granted. Both valid: grant = ~last_grant (round-robin). Neither: stay IDLE.
- BUSY: m_axis_tdata/tkeep/tlast/tvalid = granted source's signals (combinational mux, zero latency); granted s_tready = m_axis_tready; non-granted s_tready=0.
- Beat transfer = m_axis_tvalid & m_axis_tready. On a transfer with tlast=1: next state IDLE, last_grant<=grant_id, increment frame count of granted source.
- Latency: first beat of a frame visible on m_axis one cycle after tvalid seen in IDLE; one idle bubble cycle between consecutive frames (IDLE re-arbitration).
- Granted source dropping tvalid mid-frame: stay BUSY, m_axis_tvalid=0, no re-arbitration; the other source waits.
- Non-granted source asserting tvalid mid-frame: ignored until IDLE; its tvalid/data must be held per AXI-Stream rules.
- Backpressure: m_axis_tready=0 stalls the granted source via its tready; no buffering, no beat loss or duplication.
- Counters wrap from 2^CNT_WIDTH-1 to 0 silently.
- grant_id holds its value in IDLE.
- Reset mid-frame: immediate return to reset values; the partial frame is truncated (no tlast emitted); downstream MAC handles runt frames.

Optional Feature:
ARB_STRICT_PRIO_EN: when defined, IDLE arbitration is strict priority: source 0 wins whenever s0_axis_tvalid=1, regardless of last_grant (control/ACK frames may starve data). When undefined, the round-robin described above applies. All other behaviour is identical.

Test Plan:
- s1 only, 3-beat frame (0x11..., 0x22..., 0x33... with tlast on beat 3), m_tready=1 -> m_axis shows 3 beats starting 1 cycle after s1_tvalid; tlast on 3rd; frame_cnt1=1, frame_cnt0=0, grant_id=1.
- Both sources continuously offer 2-beat frames, 4 each -> grant order 0,1,0,1,0,1,0,1; one bubble between frames; frame_cnt0=frame_cnt1=4; no interleaved beats.
- m_tready pattern 1,0,0,1,0,1 during a 4-beat s0 frame -> m_axis_tdata stable while stalled, s0_tready equals m_tready each cycle, exactly 4 beats delivered in order.
- s0 raises tvalid during beat 2 of a 5-beat s1 frame -> s0_tready=0 until s1 tlast handshake; s0 frame starts after one IDLE cycle.
- rstn pulsed low during beat 2 of a 4-beat frame -> m_axis_tvalid, busy, both tready go 0 immediately; counters 0; next frame after reset forwards normally.
- Build with ARB_STRICT_PRIO_EN, s0 and s1 both continuously valid for 3 s0 frames -> all 3 s0 frames granted before any s1 beat; frame_cnt1=0 until s0_tvalid drops.

Source files
------------

// File: rtl/eth_tx_stream_arbiter.sv
// Packet-level two-source arbiter for the shared 64-bit AXI-Stream Ethernet TX path.
// Define ARB_STRICT_PRIO_EN for strict source-0 priority instead of round-robin.
module eth_tx_stream_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [DATA_WIDTH-1:0]     s0_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s0_axis_tkeep,
    input  logic                      s0_axis_tvalid,
    output logic                      s0_axis_tready,
    input  logic                      s0_axis_tlast,
    input  logic [DATA_WIDTH-1:0]     s1_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s1_axis_tkeep,
    input  logic                      s1_axis_tvalid,
    output logic                      s1_axis_tready,
    input  logic                      s1_axis_tlast,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic                      busy,
    output logic                      grant_id,
    output logic [CNT_WIDTH-1:0]      frame_cnt0,
    output logic [CNT_WIDTH-1:0]      frame_cnt1
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t state;
    logic   last_grant;
    logic   arb_pick;
    logic   xfer_last;

    always_comb begin
        arb_pick = 1'b0;
`ifdef ARB_STRICT_PRIO_EN
        arb_pick = ~s0_axis_tvalid;
`else
        if (s0_axis_tvalid && s1_axis_tvalid) begin
            arb_pick = ~last_grant;
        end else begin
            arb_pick = ~s0_axis_tvalid;
        end
`endif
    end

    // Zero-latency mux: the path is only live while a frame owns it
    always_comb begin
        m_axis_tdata   = '0;
        m_axis_tkeep   = '0;
        m_axis_tvalid  = 1'b0;
        m_axis_tlast   = 1'b0;
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        if (state == BUSY) begin
            if (grant_id) begin
                m_axis_tdata   = s1_axis_tdata;
                m_axis_tkeep   = s1_axis_tkeep;
                m_axis_tvalid  = s1_axis_tvalid;
                m_axis_tlast   = s1_axis_tlast;
                s1_axis_tready = m_axis_tready;
            end else begin
                m_axis_tdata   = s0_axis_tdata;
                m_axis_tkeep   = s0_axis_tkeep;
                m_axis_tvalid  = s0_axis_tvalid;
                m_axis_tlast   = s0_axis_tlast;
                s0_axis_tready = m_axis_tready;
            end
        end
    end

    assign xfer_last = m_axis_tvalid & m_axis_tready & m_axis_tlast;
    assign busy      = (state == BUSY);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
            frame_cnt0 <= '0;
            frame_cnt1 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s0_axis_tvalid || s1_axis_tvalid) begin
                        grant_id <= arb_pick;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (xfer_last) begin
                        state      <= IDLE;
                        last_grant <= grant_id;
                        if (grant_id) begin
                            frame_cnt1 <= frame_cnt1 + CNT_ONE;
                        end else begin
                            frame_cnt0 <= frame_cnt0 + CNT_ONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_stream_arbiter.sv
// Directed self-checking bench for eth_tx_stream_arbiter.
// Build with ARB_STRICT_PRIO_EN to exercise the strict-priority variant.
module tb_eth_tx_stream_arbiter;

    localparam int DW = 64;
    localparam int KW = DW / 8;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [DW-1:0] s0_axis_tdata = '0;
    logic [KW-1:0] s0_axis_tkeep = '0;
    logic          s0_axis_tvalid = 1'b0;
    logic          s0_axis_tready;
    logic          s0_axis_tlast = 1'b0;
    logic [DW-1:0] s1_axis_tdata = '0;
    logic [KW-1:0] s1_axis_tkeep = '0;
    logic          s1_axis_tvalid = 1'b0;
    logic          s1_axis_tready;
    logic          s1_axis_tlast = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tlast;
    logic          busy;
    logic          grant_id;
    logic [CW-1:0] frame_cnt0;
    logic [CW-1:0] frame_cnt1;

    eth_tx_stream_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rstn(rstn),
        .s0_axis_tdata(s0_axis_tdata), .s0_axis_tkeep(s0_axis_tkeep),
        .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tready(s0_axis_tready),
        .s0_axis_tlast(s0_axis_tlast),
        .s1_axis_tdata(s1_axis_tdata), .s1_axis_tkeep(s1_axis_tkeep),
        .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tready(s1_axis_tready),
        .s1_axis_tlast(s1_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
        .busy(busy), .grant_id(grant_id),
        .frame_cnt0(frame_cnt0), .frame_cnt1(frame_cnt1)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [DW-1:0] q0_d[$], q1_d[$];
    bit            q0_l[$], q1_l[$];
    bit            en0 = 0, en1 = 0;

    logic [DW-1:0] cap_d[$];
    bit            cap_l[$], cap_g[$];
    int            cap_c[$];

    logic          snap_s0r, snap_s1r, snap_mv, snap_ml, snap_busy;
    logic [DW-1:0] snap_md;

    localparam logic [DW-1:0] BASE_A = 64'hA000_0000_0000_0000;
    localparam logic [DW-1:0] BASE_B = 64'hB000_0000_0000_0000;
    localparam logic [DW-1:0] BASE_C = 64'hC000_0000_0000_0000;
    localparam logic [DW-1:0] BASE_D = 64'hD000_0000_0000_0000;
    localparam logic [DW-1:0] BASE_E = 64'hE000_0000_0000_0000;
    localparam logic [DW-1:0] BASE_F = 64'hF000_0000_0000_0000;
    localparam logic [DW-1:0] BASE_G = 64'h6000_0000_0000_0000;

    task automatic drive();
        s0_axis_tvalid = en0 && (q0_d.size() > 0);
        s0_axis_tdata  = (q0_d.size() > 0) ? q0_d[0] : '0;
        s0_axis_tlast  = (q0_l.size() > 0) ? q0_l[0] : 1'b0;
        s0_axis_tkeep  = 8'hFF;
        s1_axis_tvalid = en1 && (q1_d.size() > 0);
        s1_axis_tdata  = (q1_d.size() > 0) ? q1_d[0] : '0;
        s1_axis_tlast  = (q1_l.size() > 0) ? q1_l[0] : 1'b0;
        s1_axis_tkeep  = 8'hFF;
    endtask

    task automatic add_frame(input int src, input logic [DW-1:0] base, input int n);
        for (int b = 0; b < n; b++) begin
            if (src == 0) begin
                q0_d.push_back(base + DW'(b));
                q0_l.push_back(b == n - 1);
            end else begin
                q1_d.push_back(base + DW'(b));
                q1_l.push_back(b == n - 1);
            end
        end
    endtask

    task automatic clear_cap();
        cap_d.delete(); cap_l.delete(); cap_g.delete(); cap_c.delete();
    endtask

    // One clock: sample at negedge, advance sources after the rising edge
    task automatic step();
        bit hs0, hs1;
        @(negedge clk);
        snap_s0r  = s0_axis_tready;
        snap_s1r  = s1_axis_tready;
        snap_mv   = m_axis_tvalid;
        snap_md   = m_axis_tdata;
        snap_ml   = m_axis_tlast;
        snap_busy = busy;
        hs0 = s0_axis_tvalid && s0_axis_tready;
        hs1 = s1_axis_tvalid && s1_axis_tready;
        if (m_axis_tvalid && m_axis_tready) begin
            cap_d.push_back(m_axis_tdata);
            cap_l.push_back(m_axis_tlast);
            cap_g.push_back(grant_id);
            cap_c.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (hs0) begin void'(q0_d.pop_front()); void'(q0_l.pop_front()); end
        if (hs1) begin void'(q1_d.pop_front()); void'(q1_l.pop_front()); end
        drive();
    endtask

    task automatic run_until_empty(input string name);
        for (int k = 0; k < 200 && (q0_d.size() > 0 || q1_d.size() > 0); k++) step();
        step();
        n_cmp++;
        if (q0_d.size() != 0 || q1_d.size() != 0) begin
            n_bad++;
            $display("FAIL %s_timeout: beats left %0d/%0d required 0/0", name, q0_d.size(), q1_d.size());
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        en0 = 0; en1 = 0;
        q0_d.delete(); q0_l.delete(); q1_d.delete(); q1_l.delete();
        drive();
        m_axis_tready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        clear_cap();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        s0_axis_tvalid = 1'b1; s1_axis_tvalid = 1'b1;
        s0_axis_tdata = 64'h55; s1_axis_tdata = 64'h66;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({m_axis_tvalid, m_axis_tlast, busy, grant_id, s0_axis_tready, s1_axis_tready} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b required 000000",
                {m_axis_tvalid, m_axis_tlast, busy, grant_id, s0_axis_tready, s1_axis_tready});
        end
        n_cmp++;
        if (m_axis_tdata !== '0 || m_axis_tkeep !== '0) begin
            n_bad++;
            $display("FAIL reset_data: got %h/%h required 0/0", m_axis_tdata, m_axis_tkeep);
        end
        n_cmp++;
        if (frame_cnt0 !== '0 || frame_cnt1 !== '0) begin
            n_bad++;
            $display("FAIL reset_cnt: got %0d/%0d required 0/0", frame_cnt0, frame_cnt1);
        end
        do_reset();
    endtask

    task automatic test_single_s1();
        int t0;
        do_reset();
        add_frame(1, 64'h1111_1111_1111_1111, 1);
        add_frame(1, 64'h2222_2222_2222_2222, 1);
        add_frame(1, 64'h3333_3333_3333_3333, 1);
        q1_l[0] = 0; q1_l[1] = 0;
        en1 = 1;
        drive();
        t0 = cyc;
        step();
        n_cmp++;
        if (snap_mv !== 1'b0 || snap_s1r !== 1'b0) begin
            n_bad++;
            $display("FAIL s1_idle_cycle: got valid=%b ready=%b required 0/0", snap_mv, snap_s1r);
        end
        run_until_empty("s1_single");
        n_cmp++;
        if (cap_d.size() != 3) begin
            n_bad++;
            $display("FAIL s1_beats: got %0d required 3", cap_d.size());
        end else begin
            n_cmp++;
            if (cap_d[0] !== 64'h1111_1111_1111_1111 || cap_d[1] !== 64'h2222_2222_2222_2222 ||
                cap_d[2] !== 64'h3333_3333_3333_3333) begin
                n_bad++;
                $display("FAIL s1_data: got %h %h %h", cap_d[0], cap_d[1], cap_d[2]);
            end
            n_cmp++;
            if ({cap_l[0], cap_l[1], cap_l[2]} !== 3'b001) begin
                n_bad++;
                $display("FAIL s1_last: got %b required 001", {cap_l[0], cap_l[1], cap_l[2]});
            end
            n_cmp++;
            if (cap_c[0] != t0 + 1 || cap_c[2] != t0 + 3) begin
                n_bad++;
                $display("FAIL s1_latency: got %0d..%0d required %0d..%0d",
                    cap_c[0], cap_c[2], t0 + 1, t0 + 3);
            end
        end
        n_cmp++;
        if (frame_cnt1 !== 32'd1 || frame_cnt0 !== 32'd0 || grant_id !== 1'b1) begin
            n_bad++;
            $display("FAIL s1_status: got cnt1=%0d cnt0=%0d gid=%b required 1/0/1",
                frame_cnt1, frame_cnt0, grant_id);
        end
    endtask

`ifndef ARB_STRICT_PRIO_EN
    task automatic test_round_robin();
        int t0, k, src, f, b;
        logic [DW-1:0] exp_d;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            add_frame(0, BASE_A + DW'(i * 16), 2);
            add_frame(1, BASE_B + DW'(i * 16), 2);
        end
        en0 = 1; en1 = 1;
        drive();
        t0 = cyc;
        run_until_empty("rr");
        n_cmp++;
        if (cap_d.size() != 16) begin
            n_bad++;
            $display("FAIL rr_beats: got %0d required 16", cap_d.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                k = i / 2; src = k % 2; f = k / 2; b = i % 2;
                exp_d = (src == 1 ? BASE_B : BASE_A) + DW'(f * 16 + b);
                n_cmp++;
                if (cap_d[i] !== exp_d || cap_g[i] !== src[0] || cap_c[i] != t0 + 1 + 3 * k + b) begin
                    n_bad++;
                    $display("FAIL rr_beat%0d: got %h g=%b c=%0d required %h g=%0d c=%0d",
                        i, cap_d[i], cap_g[i], cap_c[i], exp_d, src, t0 + 1 + 3 * k + b);
                end
            end
        end
        n_cmp++;
        if (frame_cnt0 !== 32'd4 || frame_cnt1 !== 32'd4) begin
            n_bad++;
            $display("FAIL rr_cnt: got %0d/%0d required 4/4", frame_cnt0, frame_cnt1);
        end
    endtask
`else
    task automatic test_strict_prio();
        int t0;
        do_reset();
        for (int i = 0; i < 3; i++) add_frame(0, BASE_A + DW'(i * 16), 2);
        add_frame(1, BASE_B, 2);
        en0 = 1; en1 = 1;
        drive();
        t0 = cyc;
        for (int k = 0; k < 100 && q0_d.size() > 0; k++) step();
        n_cmp++;
        if (frame_cnt1 !== 32'd0 || frame_cnt0 !== 32'd3) begin
            n_bad++;
            $display("FAIL sp_cnt_mid: got cnt0=%0d cnt1=%0d required 3/0", frame_cnt0, frame_cnt1);
        end
        run_until_empty("sp");
        n_cmp++;
        if (cap_d.size() != 8) begin
            n_bad++;
            $display("FAIL sp_beats: got %0d required 8", cap_d.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_cmp++;
                if (cap_g[i] !== 1'b0 || cap_d[i] !== BASE_A + DW'((i / 2) * 16 + i % 2)) begin
                    n_bad++;
                    $display("FAIL sp_s0_beat%0d: got %h g=%b", i, cap_d[i], cap_g[i]);
                end
            end
            n_cmp++;
            if (cap_d[6] !== BASE_B || cap_g[6] !== 1'b1 || cap_c[6] != t0 + 10) begin
                n_bad++;
                $display("FAIL sp_s1_start: got %h g=%b c=%0d required %h g=1 c=%0d",
                    cap_d[6], cap_g[6], cap_c[6], BASE_B, t0 + 10);
            end
        end
        n_cmp++;
        if (frame_cnt1 !== 32'd1) begin
            n_bad++;
            $display("FAIL sp_cnt_end: got %0d required 1", frame_cnt1);
        end
    endtask
`endif

    task automatic test_backpressure();
        bit pat [6] = '{1, 0, 0, 1, 0, 1};
        int idx;
        do_reset();
        add_frame(0, BASE_C, 4);
        en0 = 1;
        drive();
        step();
        idx = 0;
        for (int i = 0; i < 6; i++) begin
            m_axis_tready = pat[i];
            step();
            n_cmp++;
            if (snap_s0r !== pat[i] || snap_mv !== 1'b1 || snap_md !== BASE_C + DW'(idx)) begin
                n_bad++;
                $display("FAIL bp_cycle%0d: got rdy=%b v=%b d=%h required rdy=%b v=1 d=%h",
                    i, snap_s0r, snap_mv, snap_md, pat[i], BASE_C + DW'(idx));
            end
            if (pat[i]) idx++;
        end
        m_axis_tready = 1'b1;
        step();
        n_cmp++;
        if (snap_md !== BASE_C + DW'(3) || snap_ml !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_last: got %h l=%b required %h l=1", snap_md, snap_ml, BASE_C + DW'(3));
        end
        step();
        n_cmp++;
        if (cap_d.size() != 4) begin
            n_bad++;
            $display("FAIL bp_beats: got %0d required 4", cap_d.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (cap_d[i] !== BASE_C + DW'(i)) begin
                    n_bad++;
                    $display("FAIL bp_order%0d: got %h required %h", i, cap_d[i], BASE_C + DW'(i));
                end
            end
        end
        n_cmp++;
        if (frame_cnt0 !== 32'd1) begin
            n_bad++;
            $display("FAIL bp_cnt: got %0d required 1", frame_cnt0);
        end
    endtask

    task automatic test_mid_frame_request();
        int t0;
        do_reset();
        add_frame(1, BASE_D, 5);
        en1 = 1;
        drive();
        t0 = cyc;
        step();
        step();
        add_frame(0, BASE_E, 2);
        en0 = 1;
        drive();
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (snap_s0r !== 1'b0 || snap_s1r !== 1'b1 || snap_md !== BASE_D + DW'(i + 1)) begin
                n_bad++;
                $display("FAIL mid_hold%0d: got s0r=%b s1r=%b d=%h required 0/1/%h",
                    i, snap_s0r, snap_s1r, snap_md, BASE_D + DW'(i + 1));
            end
        end
        step();
        n_cmp++;
        if (snap_mv !== 1'b0 || snap_s0r !== 1'b0 || snap_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_bubble: got v=%b s0r=%b busy=%b required 0/0/0",
                snap_mv, snap_s0r, snap_busy);
        end
        run_until_empty("mid");
        n_cmp++;
        if (cap_d.size() != 7) begin
            n_bad++;
            $display("FAIL mid_beats: got %0d required 7", cap_d.size());
        end else begin
            n_cmp++;
            if (cap_d[5] !== BASE_E || cap_g[5] !== 1'b0 || cap_c[5] != t0 + 7) begin
                n_bad++;
                $display("FAIL mid_s0_start: got %h g=%b c=%0d required %h g=0 c=%0d",
                    cap_d[5], cap_g[5], cap_c[5], BASE_E, t0 + 7);
            end
        end
        n_cmp++;
        if (frame_cnt0 !== 32'd1 || frame_cnt1 !== 32'd1) begin
            n_bad++;
            $display("FAIL mid_cnt: got %0d/%0d required 1/1", frame_cnt0, frame_cnt1);
        end
    endtask

    task automatic test_reset_mid_frame();
        int t0;
        add_frame(0, BASE_F, 4);
        en0 = 1;
        drive();
        step();
        step();
        rstn = 1'b0;
        #1;
        n_cmp++;
        if ({m_axis_tvalid, busy, s0_axis_tready, s1_axis_tready} !== 4'b0) begin
            n_bad++;
            $display("FAIL rstmid_ctrl: got %b required 0000",
                {m_axis_tvalid, busy, s0_axis_tready, s1_axis_tready});
        end
        n_cmp++;
        if (frame_cnt0 !== '0 || frame_cnt1 !== '0) begin
            n_bad++;
            $display("FAIL rstmid_cnt: got %0d/%0d required 0/0", frame_cnt0, frame_cnt1);
        end
        en0 = 0;
        q0_d.delete(); q0_l.delete();
        drive();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        clear_cap();
        add_frame(0, BASE_G, 2);
        en0 = 1;
        drive();
        t0 = cyc;
        run_until_empty("rstmid");
        n_cmp++;
        if (cap_d.size() != 2) begin
            n_bad++;
            $display("FAIL rstmid_beats: got %0d required 2", cap_d.size());
        end else begin
            n_cmp++;
            if (cap_d[0] !== BASE_G || cap_d[1] !== BASE_G + DW'(1) || cap_c[0] != t0 + 1) begin
                n_bad++;
                $display("FAIL rstmid_frame: got %h %h c=%0d required %h %h c=%0d",
                    cap_d[0], cap_d[1], cap_c[0], BASE_G, BASE_G + DW'(1), t0 + 1);
            end
        end
        n_cmp++;
        if (frame_cnt0 !== 32'd1) begin
            n_bad++;
            $display("FAIL rstmid_cnt_after: got %0d required 1", frame_cnt0);
        end
    endtask

    initial begin
        test_reset();
        test_single_s1();
`ifndef ARB_STRICT_PRIO_EN
        test_round_robin();
`else
        test_strict_prio();
`endif
        test_backpressure();
        test_mid_frame_request();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
